// File: rtl/floo_tile_link_isolator.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// floo_tile_link_isolator : per-port drain/isolate/wake gating of one channel
// Rev 1.0
// -----------------------------------------------------------------------------
module floo_tile_link_isolator #(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           isolate_req_i,
  output logic [NumPorts-1:0]           isolated_o,
  output logic [NumPorts-1:0]           timeout_o,
  // ingress: neighbour -> router
  input  logic [NumPorts-1:0]           lnk_valid_i,
  output logic [NumPorts-1:0]           lnk_ready_o,
  input  logic [NumPorts*DataWidth-1:0] lnk_data_i,
  input  logic [NumPorts-1:0]           lnk_last_i,
  output logic [NumPorts-1:0]           rtr_valid_o,
  input  logic [NumPorts-1:0]           rtr_ready_i,
  output logic [NumPorts*DataWidth-1:0] rtr_data_o,
  output logic [NumPorts-1:0]           rtr_last_o,
  // egress: router -> neighbour
  input  logic [NumPorts-1:0]           rtr_valid_i,
  output logic [NumPorts-1:0]           rtr_ready_o,
  input  logic [NumPorts*DataWidth-1:0] rtr_data_i,
  input  logic [NumPorts-1:0]           rtr_last_i,
  output logic [NumPorts-1:0]           lnk_valid_o,
  input  logic [NumPorts-1:0]           lnk_ready_i,
  output logic [NumPorts*DataWidth-1:0] lnk_data_o,
  output logic [NumPorts-1:0]           lnk_last_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2,
    ST_WAKE     = 2'd3
  } port_state_e;

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int unsigned         CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(TimeoutCycles);

  assign rtr_data_o = lnk_data_i;
  assign rtr_last_o = lnk_last_i;
  assign lnk_data_o = rtr_data_i;
  assign lnk_last_o = rtr_last_i;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    port_state_e         state_q;
    port_state_e         state_d;
    logic                ing_pkt_q;
    logic                egr_pkt_q;
    logic                ing_open;
    logic                egr_open;
    logic                ing_hs;
    logic                egr_hs;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    // In DRAIN only a direction already carrying a packet stays open.
    assign ing_open = (state_q == ST_ACTIVE) || ((state_q == ST_DRAIN) && ing_pkt_q);
    assign egr_open = (state_q == ST_ACTIVE) || ((state_q == ST_DRAIN) && egr_pkt_q);

    assign rtr_valid_o[p] = lnk_valid_i[p] & ing_open;
    assign lnk_ready_o[p] = rtr_ready_i[p] & ing_open;
    assign lnk_valid_o[p] = rtr_valid_i[p] & egr_open;
    assign rtr_ready_o[p] = lnk_ready_i[p] & egr_open;

    assign ing_hs = lnk_valid_i[p] & rtr_ready_i[p] & ing_open;
    assign egr_hs = rtr_valid_i[p] & lnk_ready_i[p] & egr_open;

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
        ST_ACTIVE: begin
          if (isolate_req_i[p]) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Abort has priority over completing the drain.
          if (!isolate_req_i[p])            state_d = ST_ACTIVE;
          else if (!ing_pkt_q && !egr_pkt_q) state_d = ST_ISOLATED;
        end
        ST_ISOLATED: begin
          if (!isolate_req_i[p]) state_d = ST_WAKE;
        end
        ST_WAKE: begin
          state_d = ST_ACTIVE;
        end
        default: begin
          state_d = ST_ACTIVE;
        end
      endcase

      // Counter is zero on the first DRAIN cycle and saturates at the limit.
      if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
        if (cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
        else                 cnt_d = cnt_q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q   <= ST_ACTIVE;
        ing_pkt_q <= 1'b0;
        egr_pkt_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (ing_hs) ing_pkt_q <= ~lnk_last_i[p];
        if (egr_hs) egr_pkt_q <= ~rtr_last_i[p];
      end
    end

    assign isolated_o[p] = (state_q == ST_ISOLATED);
    assign timeout_o[p]  = (TimeoutCycles != 0) && (state_q == ST_DRAIN) && (cnt_q == CntMax);
  end

endmodule
`default_nettype wire

// File: tb/tb_floo_tile_link_isolator.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_floo_tile_link_isolator : random traffic against a packet-level model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_floo_tile_link_isolator;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  localparam int M_ACT  = 0;
  localparam int M_DRN  = 1;
  localparam int M_ISO  = 2;
  localparam int M_WAKE = 3;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [NP-1:0]    isolate_req_i, isolated_o, timeout_o;
  logic [NP-1:0]    lnk_valid_i, lnk_ready_o, lnk_last_i;
  logic [NP*DW-1:0] lnk_data_i;
  logic [NP-1:0]    rtr_valid_o, rtr_ready_i, rtr_last_o;
  logic [NP*DW-1:0] rtr_data_o;
  logic [NP-1:0]    rtr_valid_i, rtr_ready_o, rtr_last_i;
  logic [NP*DW-1:0] rtr_data_i;
  logic [NP-1:0]    lnk_valid_o, lnk_ready_i, lnk_last_o;
  logic [NP*DW-1:0] lnk_data_o;

  always #5 clk = ~clk;

  floo_tile_link_isolator #(
    .NumPorts(NP), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .isolate_req_i(isolate_req_i), .isolated_o(isolated_o), .timeout_o(timeout_o),
    .lnk_valid_i(lnk_valid_i), .lnk_ready_o(lnk_ready_o), .lnk_data_i(lnk_data_i), .lnk_last_i(lnk_last_i),
    .rtr_valid_o(rtr_valid_o), .rtr_ready_i(rtr_ready_i), .rtr_data_o(rtr_data_o), .rtr_last_o(rtr_last_o),
    .rtr_valid_i(rtr_valid_i), .rtr_ready_o(rtr_ready_o), .rtr_data_i(rtr_data_i), .rtr_last_i(rtr_last_i),
    .lnk_valid_o(lnk_valid_o), .lnk_ready_i(lnk_ready_i), .lnk_data_o(lnk_data_o), .lnk_last_o(lnk_last_o)
  );

  int checks = 0;
  int errors = 0;

  // Packet-level model: port mode, "inside a packet" per direction, drain age.
  int m_mode [NP];
  bit m_ing  [NP];
  bit m_egr  [NP];
  int m_dlen [NP];

  logic [NP-1:0] req_cmd, quiet, force_last, hold_low;
  logic          rst_cmd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=no-event expected=event-within-budget", tag);
  endtask

  function automatic bit ing_open(input int p);
    return (m_mode[p] == M_ACT) || (m_mode[p] == M_DRN && m_ing[p]);
  endfunction

  function automatic bit egr_open(input int p);
    return (m_mode[p] == M_ACT) || (m_mode[p] == M_DRN && m_egr[p]);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_mode[p] = M_ACT;
      m_ing[p]  = 1'b0;
      m_egr[p]  = 1'b0;
      m_dlen[p] = 0;
    end
  endtask

  task automatic drive();
    rst_ni        = rst_cmd;
    isolate_req_i = req_cmd;
    for (int p = 0; p < NP; p++) begin
      lnk_valid_i[p] = quiet[p] ? 1'b0 : 1'($urandom_range(0, 1));
      rtr_valid_i[p] = quiet[p] ? 1'b0 : 1'($urandom_range(0, 1));
      lnk_last_i[p]  = force_last[p] | ($urandom_range(0, 3) == 0);
      rtr_last_i[p]  = force_last[p] | ($urandom_range(0, 3) == 0);
      rtr_ready_i[p] = 1'($urandom_range(0, 1));
      lnk_ready_i[p] = hold_low[p] ? 1'b0 : 1'($urandom_range(0, 1));
      lnk_data_i[p*DW +: DW] = DW'($urandom);
      rtr_data_i[p*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic check_outputs();
    logic [NP-1:0] e_rv, e_lr, e_lv, e_rr, e_iso, e_to;
    for (int p = 0; p < NP; p++) begin
      e_rv[p]  = lnk_valid_i[p] & ing_open(p);
      e_lr[p]  = rtr_ready_i[p] & ing_open(p);
      e_lv[p]  = rtr_valid_i[p] & egr_open(p);
      e_rr[p]  = lnk_ready_i[p] & egr_open(p);
      e_iso[p] = (m_mode[p] == M_ISO);
      e_to[p]  = (m_mode[p] == M_DRN) && (m_dlen[p] > TO);
    end
    chk("rtr_valid_o", 64'(rtr_valid_o), 64'(e_rv));
    chk("lnk_ready_o", 64'(lnk_ready_o), 64'(e_lr));
    chk("lnk_valid_o", 64'(lnk_valid_o), 64'(e_lv));
    chk("rtr_ready_o", 64'(rtr_ready_o), 64'(e_rr));
    chk("isolated_o",  64'(isolated_o),  64'(e_iso));
    chk("timeout_o",   64'(timeout_o),   64'(e_to));
    chk("rtr_data_o",  rtr_data_o, lnk_data_i);
    chk("lnk_data_o",  lnk_data_o, rtr_data_i);
    chk("rtr_last_o",  64'(rtr_last_o), 64'(lnk_last_i));
    chk("lnk_last_o",  64'(lnk_last_o), 64'(rtr_last_i));
  endtask

  task automatic model_step();
    int nm;
    bit hs_i, hs_e;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      hs_i = lnk_valid_i[p] && rtr_ready_i[p] && ing_open(p);
      hs_e = rtr_valid_i[p] && lnk_ready_i[p] && egr_open(p);
      nm = m_mode[p];
      if (m_mode[p] == M_ACT && isolate_req_i[p]) nm = M_DRN;
      else if (m_mode[p] == M_DRN && !isolate_req_i[p]) nm = M_ACT;
      else if (m_mode[p] == M_DRN && !m_ing[p] && !m_egr[p]) nm = M_ISO;
      else if (m_mode[p] == M_ISO && !isolate_req_i[p]) nm = M_WAKE;
      else if (m_mode[p] == M_WAKE) nm = M_ACT;
      m_dlen[p] = (nm == M_DRN) ? ((m_mode[p] == M_DRN) ? m_dlen[p] + 1 : 1) : 0;
      m_mode[p] = nm;
      if (hs_i) m_ing[p] = !lnk_last_i[p];
      if (hs_e) m_egr[p] = !rtr_last_i[p];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no-finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_ni = 1'b0; isolate_req_i = '0;
    lnk_valid_i = '0; lnk_last_i = '0; lnk_data_i = '0; lnk_ready_i = '0;
    rtr_valid_i = '0; rtr_last_i = '0; rtr_data_i = '0; rtr_ready_i = '0;
    req_cmd = '0; quiet = '0; force_last = '0; hold_low = '0; rst_cmd = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_isolated", 64'(isolated_o), 64'(0));
    chk("reset_timeout",  64'(timeout_o),  64'(0));
    rst_cmd = 1'b1;
    run(40);

    // Idle port 2 isolates in two edges while the others keep flowing.
    force_last[2] = 1'b1;
    n = 0;
    while ((m_ing[2] || m_egr[2]) && n < 200) begin cycle(); n++; end
    if (m_ing[2] || m_egr[2]) bound_fail("p2_idle_wait");
    quiet[2] = 1'b1;
    req_cmd = 4'b0100;
    cycle();
    #1 chk("p2_drain_not_isolated", 64'(isolated_o[2]), 64'(0));
    cycle();
    #1 chk("p2_isolated", 64'(isolated_o[2]), 64'(1));
    quiet[2] = 1'b0; force_last[2] = 1'b0;
    run(10);

    // Port 0 isolates while an egress packet is in flight.
    n = 0;
    while (!m_egr[0] && n < 200) begin cycle(); n++; end
    if (!m_egr[0]) bound_fail("p0_pkt_wait");
    req_cmd[0] = 1'b1;
    n = 0;
    while (m_mode[0] != M_ISO && n < 300) begin cycle(); n++; end
    if (m_mode[0] != M_ISO) bound_fail("p0_iso_wait");
    #1 chk("p0_isolated", 64'(isolated_o[0]), 64'(1));

    // Port 1 stalled mid-packet: timeout from the 9th DRAIN cycle.
    n = 0;
    while (!m_egr[1] && n < 200) begin cycle(); n++; end
    if (!m_egr[1]) bound_fail("p1_pkt_wait");
    hold_low[1] = 1'b1;
    req_cmd[1] = 1'b1;
    cycle();
    for (int k = 1; k <= 12; k++) begin
      #1 chk("p1_timeout_age", 64'(timeout_o[1]), 64'(k >= 9));
      cycle();
    end
    hold_low[1] = 1'b0;
    n = 0;
    while (m_mode[1] != M_ISO && n < 300) begin cycle(); n++; end
    if (m_mode[1] != M_ISO) bound_fail("p1_iso_wait");
    #1 chk("p1_timeout_cleared", 64'(timeout_o[1]), 64'(0));
    chk("p1_isolated", 64'(isolated_o[1]), 64'(1));

    // Port 3 drain abort with a packet still open.
    n = 0;
    while (!m_egr[3] && n < 200) begin cycle(); n++; end
    if (!m_egr[3]) bound_fail("p3_pkt_wait");
    hold_low[3] = 1'b1;
    req_cmd[3] = 1'b1;
    run(2);
    req_cmd[3] = 1'b0;
    cycle();
    #1 chk("p3_abort_no_iso", 64'(isolated_o[3]), 64'(0));
    hold_low[3] = 1'b0;
    run(10);

    // Port 3 isolate, wake for one cycle, then immediate re-request.
    req_cmd[3] = 1'b1;
    n = 0;
    while (m_mode[3] != M_ISO && n < 300) begin cycle(); n++; end
    if (m_mode[3] != M_ISO) bound_fail("p3_iso_wait");
    req_cmd[3] = 1'b0;
    cycle();
    #1 chk("p3_wake_not_isolated", 64'(isolated_o[3]), 64'(0));
    req_cmd[3] = 1'b1;
    run(2);
    req_cmd[3] = 1'b0;
    run(6);

    // Reset while port 0 is isolated and port 1 has timed out in DRAIN.
    req_cmd = '0;
    run(6);
    n = 0;
    while (!m_egr[1] && n < 200) begin cycle(); n++; end
    if (!m_egr[1]) bound_fail("p1_pkt_wait2");
    hold_low[1] = 1'b1;
    req_cmd = 4'b0011;
    n = 0;
    while (!(m_mode[0] == M_ISO && m_mode[1] == M_DRN && m_dlen[1] > TO) && n < 300) begin cycle(); n++; end
    if (!(m_mode[0] == M_ISO && m_dlen[1] > TO)) bound_fail("pre_reset_wait");
    #1 chk("pre_reset_timeout1", 64'(timeout_o[1]), 64'(1));
    chk("pre_reset_iso0", 64'(isolated_o[0]), 64'(1));
    rst_cmd = 1'b0;
    cycle();
    #1 chk("post_reset_isolated", 64'(isolated_o), 64'(0));
    chk("post_reset_timeout", 64'(timeout_o), 64'(0));
    rst_cmd = 1'b1; req_cmd = '0; hold_low = '0; force_last = '1;
    run(6);
    force_last = '0;

    // Random request churn.
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) begin
        req_cmd  = NP'($urandom);
        hold_low = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
